// File: rtl/exc_pkg.sv
// Shared types for the exception pipeline tracker: cause codes, slot layout and
// the commit-side request FSM states.
package exc_pkg;

  localparam int SLOT_EXC_W = 5;
  localparam int SLOT_PC_W  = 32;

  typedef enum logic [4:0] {
    EXC_NONE    = 5'd0,
    EXC_ADEL    = 5'd4,
    EXC_ADES    = 5'd5,
    EXC_SYSCALL = 5'd8,
    EXC_RI      = 5'd10,
    EXC_OV      = 5'd12
  } exc_code_e;

  typedef struct packed {
    logic                  valid;
    logic [SLOT_EXC_W-1:0] exc;
    logic [SLOT_PC_W-1:0]  pc;
    logic                  bd;
  } exc_slot_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_FLUSH
  } exc_state_e;

endpackage

// File: rtl/exc_merge_stage.sv
// One pipeline slot: registers the upstream instruction's state and merges its
// carried code with this stage's local detection (older code wins).
module exc_merge_stage
  import exc_pkg::*;
#(
  parameter int              EXC_W    = 5,
  parameter int              PC_W     = 32,
  parameter logic [PC_W-1:0] RESET_PC = PC_W'(32'h0000_3000)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             hold,
  input  logic             bubble,
  input  logic             kill,
  input  logic             inValid,
  input  logic [EXC_W-1:0] inExc,
  input  logic [PC_W-1:0]  inPc,
  input  logic             inBd,
  input  logic [EXC_W-1:0] curExc,
  output logic             valid,
  output logic [PC_W-1:0]  pc,
  output logic             bd,
  output logic [EXC_W-1:0] mergedExc
);

  logic [EXC_W-1:0] exc;

  // Kill keeps pc/bd so the slot still names a restartable macro-PC.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid <= 1'b0;
      exc   <= '0;
      pc    <= RESET_PC;
      bd    <= 1'b0;
    end else if (kill) begin
      valid <= 1'b0;
      exc   <= '0;
    end else if (!hold) begin
      if (bubble) begin
        valid <= 1'b0;
        exc   <= '0;
      end else begin
        valid <= inValid;
        exc   <= inExc;
      end
      pc <= inPc;
      bd <= inBd;
    end
  end

  assign mergedExc = (exc != EXC_W'(EXC_NONE)) ? exc :
                     (valid ? curExc : EXC_W'(EXC_NONE));

endmodule

// File: rtl/exc_pipe_tracker.sv
// Carries exception codes down an N-stage pipeline and raises a held CP0 request
// at commit. Optional request counter output enabled by the EXC_CNT_EN macro.
module exc_pipe_tracker
  import exc_pkg::*;
#(
  parameter int              STAGES      = 4,
  parameter int              STALL_STAGE = 1,
  parameter int              EXC_W       = 5,
  parameter int              PC_W        = 32,
  parameter logic [PC_W-1:0] RESET_PC    = PC_W'(32'h0000_3000)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    stall,
  input  logic                    flush_i,
  input  logic                    f_valid,
  input  logic [PC_W-1:0]         f_pc,
  input  logic                    f_bd,
  input  logic [EXC_W-1:0]        f_exc,
  input  logic [STAGES*EXC_W-1:0] cur_exc,
  input  logic                    int_pend,
  input  logic                    exc_ack,
  output logic [STAGES*EXC_W-1:0] stage_exc,
  output logic                    exc_req,
  output logic [EXC_W-1:0]        exc_code_o,
  output logic                    exc_int_o,
  output logic [PC_W-1:0]         exc_pc_o,
  output logic                    exc_bd_o,
  output logic                    flush_o
`ifdef EXC_CNT_EN
  ,
  output logic [31:0]             exc_cnt
`endif
);

  localparam int LAST = STAGES - 1;

  logic             stgValid [STAGES];
  logic [PC_W-1:0]  stgPc    [STAGES];
  logic             stgBd    [STAGES];
  logic [EXC_W-1:0] stgExc   [STAGES];

  exc_state_e state, stateNext;
  logic       takeReq, killAll, freeze;
  logic       intTake, codeTake;

  assign stgValid[0] = f_valid;
  assign stgPc[0]    = f_pc;
  assign stgBd[0]    = f_bd;
  assign stgExc[0]   = (f_exc != EXC_W'(EXC_NONE)) ? f_exc :
                       (f_valid ? cur_exc[0 +: EXC_W] : EXC_W'(EXC_NONE));

  // Slots up to STALL_STAGE hold on stall; the next one takes a bubble that
  // still carries the stalled macro-PC.
  for (genvar k = 1; k < STAGES; k++) begin : gSlot
    localparam bit HoldOnStall   = (k <= STALL_STAGE);
    localparam bit BubbleOnStall = (k == STALL_STAGE + 1);

    exc_merge_stage #(
      .EXC_W   (EXC_W),
      .PC_W    (PC_W),
      .RESET_PC(RESET_PC)
    ) uStage (
      .clk      (clk),
      .reset    (reset),
      .hold     (freeze | (stall & HoldOnStall)),
      .bubble   (stall & BubbleOnStall),
      .kill     (killAll),
      .inValid  (stgValid[k-1]),
      .inExc    (stgExc[k-1]),
      .inPc     (stgPc[k-1]),
      .inBd     (stgBd[k-1]),
      .curExc   (cur_exc[k*EXC_W +: EXC_W]),
      .valid    (stgValid[k]),
      .pc       (stgPc[k]),
      .bd       (stgBd[k]),
      .mergedExc(stgExc[k])
    );
  end

  for (genvar k = 0; k < STAGES; k++) begin : gStageOut
    assign stage_exc[k*EXC_W +: EXC_W] = stgExc[k];
  end

  assign intTake  = int_pend & stgValid[LAST];
  assign codeTake = (stgExc[LAST] != EXC_W'(EXC_NONE));

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= stateNext;
  end

  // A request taken this cycle outranks an external flush.
  always_comb begin
    stateNext = state;
    takeReq   = 1'b0;
    killAll   = 1'b0;
    freeze    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (intTake || codeTake) begin
          takeReq   = 1'b1;
          stateNext = ST_REQ;
        end else if (flush_i) begin
          killAll = 1'b1;
        end
      end
      ST_REQ: begin
        freeze = 1'b1;
        if (exc_ack) stateNext = ST_FLUSH;
      end
      ST_FLUSH: begin
        killAll   = 1'b1;
        stateNext = ST_IDLE;
      end
      default: stateNext = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      exc_code_o <= '0;
      exc_int_o  <= 1'b0;
      exc_pc_o   <= RESET_PC;
      exc_bd_o   <= 1'b0;
    end else if (takeReq) begin
      exc_code_o <= intTake ? EXC_W'(EXC_NONE) : stgExc[LAST];
      exc_int_o  <= intTake;
      exc_pc_o   <= stgPc[LAST];
      exc_bd_o   <= stgBd[LAST];
    end
  end

  assign exc_req = (state == ST_REQ);
  assign flush_o = (state == ST_FLUSH);

`ifdef EXC_CNT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      exc_cnt <= '0;
    end else if ((state == ST_REQ) && exc_ack && (exc_cnt != 32'hFFFF_FFFF)) begin
      exc_cnt <= exc_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_exc_pipe_tracker.sv
// Scoreboard bench for exc_pipe_tracker (STAGES=4, STALL_STAGE=1); expected
// CP0 requests are queued at injection and popped when exc_req rises.
module tb_exc_pipe_tracker;
  import exc_pkg::*;

  localparam int STAGES = 4;
  localparam int EXC_W  = 5;
  localparam int PC_W   = 32;

  logic                    clk;
  logic                    reset;
  logic                    stall;
  logic                    flush_i;
  logic                    f_valid;
  logic [PC_W-1:0]         f_pc;
  logic                    f_bd;
  logic [EXC_W-1:0]        f_exc;
  logic [STAGES*EXC_W-1:0] cur_exc;
  logic                    int_pend;
  logic                    exc_ack;
  logic [STAGES*EXC_W-1:0] stage_exc;
  logic                    exc_req;
  logic [EXC_W-1:0]        exc_code_o;
  logic                    exc_int_o;
  logic [PC_W-1:0]         exc_pc_o;
  logic                    exc_bd_o;
  logic                    flush_o;
`ifdef EXC_CNT_EN
  logic [31:0]             exc_cnt;
`endif

  typedef struct {
    logic             isInt;
    logic [EXC_W-1:0] code;
    logic [PC_W-1:0]  pc;
    logic             bd;
  } expReq_t;

  expReq_t sbQ[$];
  int      checks = 0;
  int      errors = 0;

  exc_pipe_tracker #(
    .STAGES     (STAGES),
    .STALL_STAGE(1),
    .EXC_W      (EXC_W),
    .PC_W       (PC_W),
    .RESET_PC   (32'h0000_3000)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .stall     (stall),
    .flush_i   (flush_i),
    .f_valid   (f_valid),
    .f_pc      (f_pc),
    .f_bd      (f_bd),
    .f_exc     (f_exc),
    .cur_exc   (cur_exc),
    .int_pend  (int_pend),
    .exc_ack   (exc_ack),
    .stage_exc (stage_exc),
    .exc_req   (exc_req),
    .exc_code_o(exc_code_o),
    .exc_int_o (exc_int_o),
    .exc_pc_o  (exc_pc_o),
    .exc_bd_o  (exc_bd_o),
    .flush_o   (flush_o)
`ifdef EXC_CNT_EN
    ,
    .exc_cnt   (exc_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", tag, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [PC_W-1:0] pc, input logic bd,
                               input logic [EXC_W-1:0] code);
    f_valid = 1'b1;
    f_pc    = pc;
    f_bd    = bd;
    f_exc   = code;
    tick();
    f_valid = 1'b0;
    f_pc    = '0;
    f_bd    = 1'b0;
    f_exc   = '0;
  endtask

  function automatic logic [EXC_W-1:0] stageCode(input int k);
    return stage_exc[k*EXC_W +: EXC_W];
  endfunction

  task automatic pushExp(input logic isInt, input logic [EXC_W-1:0] code,
                         input logic [PC_W-1:0] pc, input logic bd);
    expReq_t e;
    e.isInt = isInt;
    e.code  = code;
    e.pc    = pc;
    e.bd    = bd;
    sbQ.push_back(e);
  endtask

  task automatic checkReq(input string tag);
    expReq_t e;
    checkOutput({tag, "_req"}, 64'(exc_req), 64'd1);
    if (sbQ.size() == 0) begin
      checkOutput({tag, "_sbEmpty"}, 64'(sbQ.size()), 64'd1);
    end else begin
      e = sbQ.pop_front();
      checkOutput({tag, "_int"},  64'(exc_int_o),  64'(e.isInt));
      checkOutput({tag, "_code"}, 64'(exc_code_o), 64'(e.code));
      checkOutput({tag, "_pc"},   64'(exc_pc_o),   64'(e.pc));
      checkOutput({tag, "_bd"},   64'(exc_bd_o),   64'(e.bd));
    end
  endtask

  task automatic ackFlush(input string tag);
    exc_ack = 1'b1;
    tick();
    exc_ack = 1'b0;
    checkOutput({tag, "_flush"}, 64'(flush_o), 64'd1);
    checkOutput({tag, "_reqDrop"}, 64'(exc_req), 64'd0);
    tick();
    checkOutput({tag, "_flushEnd"}, 64'(flush_o), 64'd0);
    checkOutput({tag, "_killed"},
                64'({dut.stgValid[1], dut.stgValid[2], dut.stgValid[3]}), 64'd0);
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; flush_i = 1'b0; f_valid = 1'b0;
    f_pc = '0; f_bd = 1'b0; f_exc = '0; cur_exc = '0;
    int_pend = 1'b0; exc_ack = 1'b0;
    tick();
    tick();
    checkOutput("rstReq",   64'(exc_req),    64'd0);
    checkOutput("rstFlush", 64'(flush_o),    64'd0);
    checkOutput("rstPc",    64'(exc_pc_o),   64'h3000);
    checkOutput("rstCode",  64'(exc_code_o), 64'd0);
    checkOutput("rstStage", 64'(stage_exc),  64'd0);
    reset = 1'b0;

    applyStimulus(32'h3000, 1'b0, EXC_W'(EXC_ADEL));
    tick();
    tick();
    checkOutput("flowStage3", 64'(stageCode(3)), 64'd4);
    checkOutput("flowStage2", 64'(stageCode(2)), 64'd0);
    pushExp(1'b0, 5'd4, 32'h3000, 1'b0);
    tick();
    checkReq("flow");
    ackFlush("flow");

    cur_exc = (STAGES*EXC_W)'(12) << (2*EXC_W);
    applyStimulus(32'h3010, 1'b0, EXC_W'(EXC_ADEL));
    tick();
    checkOutput("olderStage2", 64'(stageCode(2)), 64'd4);
    tick();
    checkOutput("olderStage3", 64'(stageCode(3)), 64'd4);
    cur_exc = '0;
    pushExp(1'b0, 5'd4, 32'h3010, 1'b0);
    tick();
    checkReq("older");
    ackFlush("older");

    applyStimulus(32'h3004, 1'b1, 5'd0);
    stall   = 1'b1;
    f_valid = 1'b1;
    f_pc    = 32'h3008;
    tick();
    tick();
    checkOutput("stallS1Valid", 64'(dut.stgValid[1]), 64'd1);
    checkOutput("stallS1Pc",    64'(dut.stgPc[1]),    64'h3004);
    checkOutput("stallS1Bd",    64'(dut.stgBd[1]),    64'd1);
    checkOutput("stallS2Valid", 64'(dut.stgValid[2]), 64'd0);
    checkOutput("stallS2Pc",    64'(dut.stgPc[2]),    64'h3004);
    checkOutput("stallS2Bd",    64'(dut.stgBd[2]),    64'd1);
    stall   = 1'b0;
    f_valid = 1'b0;
    f_pc    = '0;
    tick();
    checkOutput("stallResume", 64'(dut.stgValid[2]), 64'd1);
    tick();
    tick();
    checkOutput("stallNoReq", 64'(exc_req), 64'd0);

    int_pend = 1'b1;
    cur_exc  = (STAGES*EXC_W)'(12) << (3*EXC_W);
    applyStimulus(32'h3040, 1'b0, 5'd0);
    tick();
    tick();
    checkOutput("intStage3", 64'(stageCode(3)), 64'd12);
    pushExp(1'b1, 5'd0, 32'h3040, 1'b0);
    tick();
    checkReq("intPrio");
    int_pend = 1'b0;
    cur_exc  = '0;
    ackFlush("intPrio");

    f_valid = 1'b1; f_pc = 32'h3020; f_bd = 1'b1; f_exc = EXC_W'(EXC_ADES);
    tick();
    f_pc = 32'h3024; f_bd = 1'b0; f_exc = '0;
    tick();
    f_pc = 32'h3028;
    tick();
    f_valid = 1'b0;
    checkOutput("heldStage3", 64'(stageCode(3)), 64'd5);
    pushExp(1'b0, 5'd5, 32'h3020, 1'b1);
    tick();
    checkReq("held");
    f_valid = 1'b1;
    f_pc    = 32'h3100;
    for (int i = 0; i < 5; i++) begin
      stall = i[0];
      tick();
      checkOutput($sformatf("heldReq%0d", i), 64'(exc_req), 64'd1);
    end
    stall   = 1'b0;
    f_valid = 1'b0;
    f_pc    = '0;
    checkOutput("heldS3Pc",    64'(dut.stgPc[3]),    64'h3024);
    checkOutput("heldS3Valid", 64'(dut.stgValid[3]), 64'd1);
    checkOutput("heldS2Pc",    64'(dut.stgPc[2]),    64'h3028);
    checkOutput("heldS1Valid", 64'(dut.stgValid[1]), 64'd0);
    checkOutput("heldCode",    64'(exc_code_o),      64'd5);
    ackFlush("held");
    checkOutput("heldPcKept", 64'(dut.stgPc[3]), 64'h3024);

    applyStimulus(32'h3050, 1'b0, 5'd0);
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    checkOutput("flushInS2", 64'(dut.stgValid[2]), 64'd0);

    exc_ack = 1'b1;
    tick();
    tick();
    exc_ack = 1'b0;
    checkOutput("idleAckReq",   64'(exc_req), 64'd0);
    checkOutput("idleAckFlush", 64'(flush_o), 64'd0);

    applyStimulus(32'h3060, 1'b0, EXC_W'(EXC_RI));
    tick();
    tick();
    flush_i = 1'b1;
    pushExp(1'b0, 5'd10, 32'h3060, 1'b0);
    tick();
    checkReq("reqBeatsFlush");
    tick();
    flush_i = 1'b0;
    checkOutput("flushInReq", 64'(exc_req), 64'd1);
    ackFlush("reqBeatsFlush");

`ifdef EXC_CNT_EN
    checkOutput("cntAccepted", 64'(exc_cnt), 64'd5);
`endif

    applyStimulus(32'h3070, 1'b0, EXC_W'(EXC_SYSCALL));
    f_valid = 1'b1;
    f_pc    = 32'h3080;
    tick();
    tick();
    f_valid = 1'b0;
    pushExp(1'b0, 5'd8, 32'h3070, 1'b0);
    tick();
    checkReq("rstInReq");
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checkOutput("rstReqDrop",  64'(exc_req),  64'd0);
    checkOutput("rstReqFlush", 64'(flush_o),  64'd0);
    checkOutput("rstReqPc",    64'(exc_pc_o), 64'h3000);
    checkOutput("rstReqSlots",
                64'({dut.stgValid[1], dut.stgValid[2], dut.stgValid[3]}), 64'd0);
`ifdef EXC_CNT_EN
    checkOutput("rstReqCnt", 64'(exc_cnt), 64'd0);
`endif
    tick();
    checkOutput("rstReqNoFlush", 64'(flush_o), 64'd0);
    checkOutput("rstReqIdle",    64'(exc_req), 64'd0);
    checkOutput("sbDrained",     64'(sbQ.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/exc_pipe_tracker.md
# exc_pipe_tracker

Parametrised exception-code carrier for the N-stage MIPS pipeline. Each stage merges the older code carried from upstream with its own detection, with the older code winning. The merged code travels with PC and BD through per-stage slot registers, with stall bubbles and flushes handled. At the commit stage a small FSM raises a held request to CP0, freezes the pipeline until acknowledged, then flushes.

## Interface
- STAGES, 4, number of stages; stage 0 is fetch input, stage STAGES-1 is commit (legal 3..8)
- STALL_STAGE, 1, stage held by `stall`; legal 1..STAGES-2
- EXC_W, 5, exception code width; code 0 = none
- PC_W, 32, PC width
- RESET_PC, 32'h0000_3000, slot PC after reset
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- stall  in  1  hazard stall at STALL_STAGE
- flush_i  in  1  external flush (eret), kills all slots
- f_valid  in  1  stage-0 instruction valid
- f_pc  in  PC_W  stage-0 PC
- f_bd  in  1  stage-0 branch-delay flag
- f_exc  in  EXC_W  stage-0 raw code (e.g. fetch AdEL)
- cur_exc  in  STAGES*EXC_W  per-stage local detection, stage k at [k*EXC_W +: EXC_W]
- int_pend  in  1  CP0 interrupt pending, level
- exc_ack  in  1  CP0 accepted request
- stage_exc  out  STAGES*EXC_W  merged code per stage, combinational
- exc_req  out  1  request to CP0, registered
- exc_code_o  out  EXC_W  latched code (0 when interrupt)
- exc_int_o  out  1  request is interrupt
- exc_pc_o  out  PC_W  victim PC
- exc_bd_o  out  1  victim BD
- flush_o  out  1  one-cycle pipeline flush pulse

## Operation
- Slot k (1..STAGES-1) holds valid, exc, pc, bd. Reset: valid=0, exc=0, pc=RESET_PC, bd=0.
- Merge: stage_exc[k] = raw!=0 ? raw : (valid ? cur_exc[k] : 0). For k=0, raw=f_exc and valid=f_valid; for k≥1, raw is slot k exc.
- Normal advance: slot k loads stage k-1 {valid, stage_exc[k-1], pc, bd}.
- Stall: slots 1..STALL_STAGE hold. Slot STALL_STAGE+1 loads a bubble: valid=0, exc=0, pc/bd copied from stage STALL_STAGE (macro-PC). Slots further down advance.
- FSM states:
  - IDLE: take a request if int_pend and commit valid, or if stage_exc[STAGES-1]!=0. Interrupt has priority. Latch code, int, pc, bd and go to REQ.
  - REQ: exc_req=1, all slots frozen, stall ignored. On exc_ack go to FLUSH.
  - FLUSH: flush_o=1; all slots get valid=0, exc=0, pc/bd kept. Next state is IDLE.
- flush_i in IDLE with no request being taken: all slots invalidated next edge. If a request is taken that cycle, the request wins and flush_i is ignored. flush_i is ignored in REQ and FLUSH.
- Outputs exc_code_o/int/pc/bd are stable throughout REQ and hold their last value otherwise. All outputs are 0 at reset, except exc_pc_o=RESET_PC.

## Timing
- Commit detection at edge t gives exc_req=1 from t+1.
- exc_ack sampled at edge t+1 gives flush_o=1 during t+1..t+2, then IDLE at t+2. Minimum request-to-idle is 2 cycles.
- exc_ack while IDLE or FLUSH is ignored.
- Reset mid-REQ: state goes to IDLE, exc_req=0 next cycle, no flush_o.
- Stage code latency: one cycle per stage. No combinational path from exc_ack to exc_req.

## Configuration
- EXC_CNT_EN: adds output `exc_cnt` (out, 32) counting requests accepted (REQ with exc_ack). Saturates at 32'hFFFF_FFFF; reset 0.
- Without EXC_CNT_EN: the port and counter are absent, and behaviour is otherwise identical.

## Structure
- Shared package `exc_pkg`: ExcCode constants (EXC_NONE=0, EXC_ADEL=4, EXC_ADES=5, EXC_RI=10, EXC_OV=12, EXC_SYSCALL=8), the slot struct typedef, and the FSM state enum.
- One sub-module, `exc_merge_stage`: a combinational older-wins merge plus the slot register with hold/bubble/flush controls, instantiated STAGES-1 times by generate.

## Test plan
- Exception flows down: STAGES=4, f_exc=4 at pc 0x3000 -> stage_exc[3]=4 after 3 cycles; exc_req next cycle with code 4, pc 0x3000.
- Older wins: f_exc=4 and cur_exc[2]=12 on the same instruction -> commit code 4, never 12.
- Stall bubble: stall=1 for 2 cycles with slot 1 at pc 0x3004, bd=1 -> slot 2 valid=0, pc 0x3004, bd=1; slot 1 unchanged.
- Interrupt priority: int_pend=1 while commit code 12 -> exc_int_o=1, exc_code_o=0, commit pc latched.
- Held request: exc_ack withheld 5 cycles -> exc_req stays 1 and slots frozen despite stall; ack -> flush_o one cycle, all valid=0, IDLE.
- Reset in REQ: exc_req=0 the next cycle, slots cleared, exc_cnt=0 (EXC_CNT_EN).
